bist_range_adr_gen: RTL and testbench
=====================================

# bist_range_adr_gen

Parametrised BIST address generator for the march-test datapath. It sweeps a programmable address window [lo_adr, hi_adr] in either direction for a programmable number of passes, with optional ping-pong direction reversal between passes. It reports end-of-pass, last-address and completion status to the BIST controller FSM. It replaces the fixed full-range up/down counter, and its `adress` output drives the memory-under-test address bus directly.

## Interface

Parameters:
- `ADR_SIZE`, 8: address width in bits; legal range is 2..16.
- `PASS_W`, 4: width of the pass-count input.

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst_adr`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle pulse that latches the configuration and begins (or restarts) a sweep.
- `lo_adr`  in  ADR_SIZE: lower window bound, inclusive; sampled on `start`.
- `hi_adr`  in  ADR_SIZE: upper window bound, inclusive; sampled on `start`.
- `up_down`  in  1: initial direction, 1 = ascending; sampled on `start`.
- `passes`  in  PASS_W: number of passes; sampled on `start`.
- `alt`  in  1: 1 = reverse direction after every pass (ping-pong); sampled on `start`.
- `step`  in  1: advance request from the controller; meaningful only while `busy` is high.
- `adress`  out  ADR_SIZE: current address (registered).
- `pass_end`  out  1: `busy` is high and `adress` is the current pass's end address.
- `last`  out  1: `pass_end` is high and this is the final pass.
- `busy`  out  1: FSM is in RUN.
- `done`  out  1: sweep complete; held high until `start` or reset.
- `err`  out  1: rejected configuration; held high until `start` or reset.

## Operation

- FSM states are IDLE, RUN and DONE. Register fields are `state`, `adress`, `pass_cnt` (PASS_W bits), `dir`, and the latched `lo`, `hi`, `npass`, `alt_r`.
- Window terms:
  - start_adr = dir ? lo : hi.
  - end_adr = dir ? hi : lo.
- On reset: state = IDLE, `adress` = 0, `pass_cnt` = 0, `dir` = 1, and all outputs are 0.
- `start` in any state:
  - Latch the configuration and clear `done` and `err`.
  - If `lo_adr > hi_adr` or `passes == 0`, go to DONE with `err` = 1 and `done` = 0. `adress` keeps its previous value.
  - Otherwise go to RUN with `adress` = start_adr (computed from the new inputs), `pass_cnt` = 0 and `dir` = `up_down`.
  - `start` in RUN aborts the current sweep and restarts it.
- RUN with `step` = 1 and `start` = 0:
  - If `adress != end_adr`, then `adress` = `adress` + 1 when `dir` = 1, or `adress` − 1 when `dir` = 0. No wrap is possible inside a valid window.
  - Else, if `pass_cnt == npass − 1`, go to DONE with `done` = 1. `adress` holds the end address.
  - Else `pass_cnt` increments. If `alt_r` = 1, `dir` toggles and `adress` holds, so the end address is the first address of the next pass. If `alt_r` = 0, `adress` reloads start_adr.
- RUN with `step` = 0: all registers hold.
- `step` in IDLE or DONE is ignored.
- Single-address window (`lo_adr == hi_adr`): every step ends a pass, and `pass_end` stays high throughout RUN.
- Arithmetic: all comparisons are unsigned and ADR_SIZE wide. The full window 0..2^ADR_SIZE−1 is legal.
- `pass_end` and `last` are decoded combinationally from registered state only. They contain no input-to-output path.

## Timing

- Latency from `start` to `busy` is one cycle; `adress` is valid in the same cycle `busy` rises.
- Each accepted `step` updates `adress` on the next edge. Full throughput is one address per cycle.
- A window of N addresses with P passes consumes exactly N·P steps when `alt` = 0, and N·P steps when `alt` = 1 (the repeated address counts once per pass).
- `done` rises, and `busy` falls, on the edge after the step taken while `last` = 1.
- If `start` and `step` are asserted together, `start` wins.
- `rst_adr` has priority over everything and aborts a sweep mid-operation.

## Structure

- Shared `bist_pkg`:
  - State encoding: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
  - Default widths.
- One sub-module, `bist_adr_step`, is natural: a combinational next-address / end-compare unit with inputs `adress`, `dir`, `lo`, `hi` and outputs `nxt_adr`, `at_end`. It is reusable by the data-background generator.
- The FSM and the pass counter live in the top module.

## Test plan

- Reset then idle: `adress` = 0, all flags = 0; `step` pulses produce no change.
- ADR_SIZE = 8, lo = 0x10, hi = 0x13, up, passes = 1, `step` held high: `adress` goes 10, 11, 12, 13. `last` is high at 13; `done` is high the next cycle and `adress` stays 13.
- Same window, down, passes = 2, `alt` = 1: sequence is 13, 12, 11, 10, 10, 11, 12, 13. `pass_end` is high at each 10 and 13 pass boundary; `done` follows the 8th step.
- Same window, up, passes = 2, `alt` = 0: sequence is 10..13, 10..13, with a reload to 10 after the first 13.
- Error and boundaries:
  - lo = 0x20, hi = 0x1F: `err` = 1 and `done` = 0 on the next cycle.
  - passes = 0: `err` = 1.
  - lo = hi = 0xFF: `pass_end` is constantly high; passes = 3 completes in 3 steps.
- Abort cases:
  - `start` in RUN with a new window 0x00..0x01: `adress` = 0x00 and `pass_cnt` = 0 on the next cycle.
  - `rst_adr` mid-sweep: back to IDLE with `adress` = 0.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared definitions for the BIST address generator family.
package bist_pkg;

   // Default widths
   localparam int unsigned ADR_SIZE_DEF = 8;
   localparam int unsigned PASS_W_DEF   = 4;

   // Sweep FSM state encoding
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/bist_adr_step.sv
// Combinational next-address and end-of-window compare for one sweep direction.
module bist_adr_step
   import bist_pkg::*;
#(
   parameter int unsigned ADR_SIZE = ADR_SIZE_DEF
) (
   input  logic [ADR_SIZE-1:0] adress,
   input  logic                dir,
   input  logic [ADR_SIZE-1:0] lo,
   input  logic [ADR_SIZE-1:0] hi,
   output logic [ADR_SIZE-1:0] nxt_adr,
   output logic                at_end
);

   // Ascending sweeps end at hi, descending at lo; neighbour address in sweep direction
   always_comb begin
      nxt_adr = dir ? (adress + ADR_SIZE'(1)) : (adress - ADR_SIZE'(1));
      at_end  = (adress == (dir ? hi : lo));
   end

endmodule

// File: rtl/bist_range_adr_gen.sv
// Programmable-window, multi-pass BIST address generator with optional ping-pong.
module bist_range_adr_gen
   import bist_pkg::*;
#(
   parameter int unsigned ADR_SIZE = ADR_SIZE_DEF,
   parameter int unsigned PASS_W   = PASS_W_DEF
) (
   input  logic                clk,
   input  logic                rst_adr,
   input  logic                start,
   input  logic [ADR_SIZE-1:0] lo_adr,
   input  logic [ADR_SIZE-1:0] hi_adr,
   input  logic                up_down,
   input  logic [PASS_W-1:0]   passes,
   input  logic                alt,
   input  logic                step,
   output logic [ADR_SIZE-1:0] adress,
   output logic                pass_end,
   output logic                last,
   output logic                busy,
   output logic                done,
   output logic                err
);

   state_t              state, state_n;
   logic [PASS_W-1:0]   pass_cnt, pass_cnt_n;
   logic                dir, dir_n;
   logic [ADR_SIZE-1:0] lo, lo_n;
   logic [ADR_SIZE-1:0] hi, hi_n;
   logic [PASS_W-1:0]   npass, npass_n;
   logic                alt_r, alt_r_n;
   logic [ADR_SIZE-1:0] adress_n;
   logic                done_n, err_n;
   logic [ADR_SIZE-1:0] nxt_adr;
   logic                at_end;
   logic                final_pass;

   bist_adr_step #(
      .ADR_SIZE(ADR_SIZE)
   ) u_step (
      .adress (adress),
      .dir    (dir),
      .lo     (lo),
      .hi     (hi),
      .nxt_adr(nxt_adr),
      .at_end (at_end)
   );

   // Status flags decoded from registered state only
   always_comb begin
      final_pass = (pass_cnt == (npass - PASS_W'(1)));
      busy       = (state == RUN);
      pass_end   = busy && at_end;
      last       = pass_end && final_pass;
   end

   // Next-state, address and pass-counter logic; start overrides step in every state
   always_comb begin
      state_n    = state;
      adress_n   = adress;
      pass_cnt_n = pass_cnt;
      dir_n      = dir;
      lo_n       = lo;
      hi_n       = hi;
      npass_n    = npass;
      alt_r_n    = alt_r;
      done_n     = done;
      err_n      = err;

      if (start) begin
         lo_n    = lo_adr;
         hi_n    = hi_adr;
         npass_n = passes;
         alt_r_n = alt;
         done_n  = 1'b0;
         err_n   = 1'b0;
         if ((lo_adr > hi_adr) || (passes == '0)) begin
            state_n = DONE;
            err_n   = 1'b1;
         end else begin
            state_n    = RUN;
            adress_n   = up_down ? lo_adr : hi_adr;
            pass_cnt_n = '0;
            dir_n      = up_down;
         end
      end else if ((state == RUN) && step) begin
         if (!at_end) begin
            adress_n = nxt_adr;
         end else if (final_pass) begin
            state_n = DONE;
            done_n  = 1'b1;
         end else begin
            pass_cnt_n = pass_cnt + PASS_W'(1);
            // Ping-pong: the end address doubles as the first address of the next pass
            if (alt_r) begin
               dir_n = ~dir;
            end else begin
               adress_n = dir ? lo : hi;
            end
         end
      end
   end

   // State register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst_adr) begin
         state    <= IDLE;
         adress   <= '0;
         pass_cnt <= '0;
         dir      <= 1'b1;
         lo       <= '0;
         hi       <= '0;
         npass    <= '0;
         alt_r    <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_n;
         adress   <= adress_n;
         pass_cnt <= pass_cnt_n;
         dir      <= dir_n;
         lo       <= lo_n;
         hi       <= hi_n;
         npass    <= npass_n;
         alt_r    <= alt_r_n;
         done     <= done_n;
         err      <= err_n;
      end
   end

endmodule

// File: tb/tb_bist_range_adr_gen.sv
// Directed self-checking bench for bist_range_adr_gen (ADR_SIZE = 8, PASS_W = 4).
module tb_bist_range_adr_gen;

   logic       clk = 1'b0;
   logic       rst_adr, start, up_down, alt, step;
   logic [7:0] lo_adr, hi_adr;
   logic [3:0] passes;
   logic [7:0] adress;
   logic       pass_end, last, busy, done, err;

   int passed = 0;
   int total  = 0;

   bist_range_adr_gen #(
      .ADR_SIZE(8),
      .PASS_W  (4)
   ) dut (
      .clk     (clk),
      .rst_adr (rst_adr),
      .start   (start),
      .lo_adr  (lo_adr),
      .hi_adr  (hi_adr),
      .up_down (up_down),
      .passes  (passes),
      .alt     (alt),
      .step    (step),
      .adress  (adress),
      .pass_end(pass_end),
      .last    (last),
      .busy    (busy),
      .done    (done),
      .err     (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic do_start(input logic [7:0] lo, input logic [7:0] hi, input logic ud,
                           input logic [3:0] np, input logic al);
      lo_adr  = lo;
      hi_adr  = hi;
      up_down = ud;
      passes  = np;
      alt     = al;
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   // expected sweeps: address, pass_end, last at each step
   logic [7:0] seq_a [8] = '{8'h13, 8'h12, 8'h11, 8'h10, 8'h10, 8'h11, 8'h12, 8'h13};
   logic       pe_a  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
   logic [7:0] seq_b [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h11, 8'h12, 8'h13};
   logic       pe_b  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      rst_adr = 1'b1; start = 1'b0; step = 1'b0; up_down = 1'b1; alt = 1'b0;
      lo_adr = '0; hi_adr = '0; passes = '0;
      tick(); tick();
      rst_adr = 1'b0;

      // reset and idle
      chk("rst_adr_val", adress, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_pass_end", pass_end, 1'b0);
      chk("rst_last", last, 1'b0);
      step = 1'b1;
      tick(); tick();
      chk("idle_step_adr", adress, 8'h00);
      chk("idle_step_busy", busy, 1'b0);

      // single pass up, start and step together (start wins)
      do_start(8'h10, 8'h13, 1'b1, 4'd1, 1'b0);
      chk("up1_busy", busy, 1'b1);
      for (int i = 0; i < 4; i++) begin
         chk("up1_adr", adress, 16'h10 + 16'(i));
         chk("up1_last", last, (i == 3) ? 1'b1 : 1'b0);
         tick();
      end
      chk("up1_done", done, 1'b1);
      chk("up1_busy_low", busy, 1'b0);
      chk("up1_adr_hold", adress, 8'h13);
      chk("up1_last_low", last, 1'b0);

      // down, two passes, ping-pong
      do_start(8'h10, 8'h13, 1'b0, 4'd2, 1'b1);
      chk("pp_done_cleared", done, 1'b0);
      for (int i = 0; i < 8; i++) begin
         chk("pp_adr", adress, seq_a[i]);
         chk("pp_pass_end", pass_end, pe_a[i]);
         chk("pp_last", last, (i == 7) ? 1'b1 : 1'b0);
         tick();
      end
      chk("pp_done", done, 1'b1);
      chk("pp_busy", busy, 1'b0);

      // up, two passes, reload
      do_start(8'h10, 8'h13, 1'b1, 4'd2, 1'b0);
      for (int i = 0; i < 8; i++) begin
         chk("rl_adr", adress, seq_b[i]);
         chk("rl_pass_end", pass_end, pe_b[i]);
         chk("rl_last", last, (i == 7) ? 1'b1 : 1'b0);
         tick();
      end
      chk("rl_done", done, 1'b1);

      // inverted window rejected, address retained
      do_start(8'h20, 8'h1F, 1'b1, 4'd1, 1'b0);
      chk("inv_err", err, 1'b1);
      chk("inv_done", done, 1'b0);
      chk("inv_busy", busy, 1'b0);
      chk("inv_adr_keep", adress, 8'h13);

      // zero passes rejected
      do_start(8'h10, 8'h13, 1'b1, 4'd0, 1'b0);
      chk("np0_err", err, 1'b1);
      chk("np0_busy", busy, 1'b0);

      // single-address window at top of range, three passes
      do_start(8'hFF, 8'hFF, 1'b1, 4'd3, 1'b0);
      chk("one_err_cleared", err, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("one_adr", adress, 8'hFF);
         chk("one_pass_end", pass_end, 1'b1);
         chk("one_last", last, (i == 2) ? 1'b1 : 1'b0);
         tick();
      end
      chk("one_done", done, 1'b1);
      chk("one_busy", busy, 1'b0);

      // step low holds, then restart mid-sweep
      do_start(8'h10, 8'h13, 1'b1, 4'd1, 1'b0);
      tick();
      chk("hold_pre", adress, 8'h11);
      step = 1'b0;
      tick(); tick();
      chk("hold_adr", adress, 8'h11);
      chk("hold_busy", busy, 1'b1);
      step = 1'b1;
      do_start(8'h00, 8'h01, 1'b1, 4'd2, 1'b0);
      chk("abort_adr", adress, 8'h00);
      chk("abort_pe", pass_end, 1'b0);
      tick();
      chk("abort_adr1", adress, 8'h01);
      chk("abort_last_first_pass", last, 1'b0);
      tick();
      chk("abort_reload", adress, 8'h00);

      // reset mid-sweep
      tick();
      rst_adr = 1'b1;
      tick();
      rst_adr = 1'b0;
      step = 1'b0;
      chk("mid_rst_adr", adress, 8'h00);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_done", done, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
